// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter for 8 requesters sharing one resource.
// A grant is held until the holder releases it, drops its request, the
// arbiter is disabled, or the grant reaches HOLD_MAX cycles. Every grant is
// followed by one idle cycle. Arbitration then resumes from the requester
// after the last holder.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : arbiter enable; low forces idle and no grant
//   req       : level-sensitive requests, bit i = requester i
//   release_i : current holder gives up the grant ("release" is a reserved word)
//   gnt       : registered one-hot grant, zero when idle
//   gnt_idx   : registered index of the granted requester, 0 when idle
//   gnt_valid : registered, high iff gnt != 0
//   timeout   : registered one-cycle pulse when the hold limit revokes a grant
//   seg       : active-low 7-segment {a,b,c,d,e,f,g} showing gnt_idx, blank when idle
module rr_grant_ctrl #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [6:0] seg
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q,    state_d;
  logic [2:0]       ptr_q,      ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       gnt_q,      gnt_d;
  logic [2:0]       gnt_idx_q,  gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q,  timeout_d;

  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       end_by_user;
  logic       end_by_hold;

  // Rotating scan starting at ptr_q; the 3-bit add wraps 7 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // User-driven terminations take precedence, so timeout only fires when
  // the hold limit is the sole reason the grant ends.
  always_comb begin
    end_by_user = !en || release_i || !req[gnt_idx_q];
    end_by_hold = (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && sel_found) begin
          state_d     = GRANT;
          gnt_d       = 8'b1 << sel_idx;
          gnt_idx_d   = sel_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (end_by_user || end_by_hold) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          timeout_d   = !end_by_user;
        end else begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    seg = 7'b1111111;
    if (gnt_valid_q) begin
      unique case (gnt_idx_q)
        3'd0: seg = 7'b0000001;
        3'd1: seg = 7'b1001111;
        3'd2: seg = 7'b0010010;
        3'd3: seg = 7'b0000110;
        3'd4: seg = 7'b1001100;
        3'd5: seg = 7'b0100100;
        3'd6: seg = 7'b0100000;
        3'd7: seg = 7'b0001111;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [6:0] seg;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  rr_grant_ctrl #(.HOLD_MAX(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .release_i (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] seg_of(input logic [2:0] idx, input logic valid);
    logic [6:0] tbl [8];
    tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};
    return valid ? tbl[idx] : 7'h7F;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt,
                           input logic [2:0] e_idx, input logic e_tmo);
    logic e_valid;
    e_valid = (e_gnt != 8'h00);
    chk({tag, ".gnt"},       gnt,             e_gnt);
    chk({tag, ".gnt_idx"},   8'(gnt_idx),     8'(e_idx));
    chk({tag, ".gnt_valid"}, 8'(gnt_valid),   8'(e_valid));
    chk({tag, ".timeout"},   8'(timeout),     8'(e_tmo));
    chk({tag, ".seg"},       8'(seg),         8'(seg_of(e_idx, e_valid)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic [7:0] r, input logic rl,
                     input logic [7:0] g, input logic [2:0] i, input logic t);
    vec_t v;
    v.en = e; v.req = r; v.rel = rl; v.gnt = g; v.idx = i; v.tmo = t;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; rel = 1'b0;
    step();
    step();
    check_out("reset", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;

    // idle with no requests
    for (int k = 0; k < 5; k++) add(1, 8'h00, 0, 8'h00, 0, 0);
    // two requesters alternate, release two cycles into each grant
    add(1, 8'h24, 0, 8'h04, 2, 0);
    add(1, 8'h24, 0, 8'h04, 2, 0);
    add(1, 8'h24, 1, 8'h00, 0, 0);
    add(1, 8'h24, 0, 8'h20, 5, 0);
    add(1, 8'h24, 0, 8'h20, 5, 0);
    add(1, 8'h24, 1, 8'h00, 0, 0);
    add(1, 8'h24, 0, 8'h04, 2, 0);
    add(1, 8'h24, 0, 8'h04, 2, 0);
    add(1, 8'h24, 1, 8'h00, 0, 0);
    add(1, 8'h24, 0, 8'h20, 5, 0);
    add(1, 8'h24, 1, 8'h00, 0, 0);       // ptr -> 6
    // en low in idle keeps ptr; then en drop mid-grant of idx 6
    add(0, 8'hFF, 0, 8'h00, 0, 0);
    add(1, 8'hFF, 0, 8'h40, 6, 0);
    add(0, 8'hFF, 0, 8'h00, 0, 0);       // ptr -> 7
    add(0, 8'hFF, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, 8'h00, 0, 0);
    add(1, 8'hFF, 0, 8'h80, 7, 0);
    add(1, 8'hFF, 1, 8'h00, 0, 0);       // ptr wraps to 0
    // req drop together with release on idx 3, then wrap from 4 to 0
    add(1, 8'h08, 0, 8'h08, 3, 0);
    add(1, 8'h01, 1, 8'h00, 0, 0);       // ptr -> 4
    add(1, 8'h09, 0, 8'h01, 0, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0);       // ptr -> 1

    foreach (vecs[n]) begin
      en = vecs[n].en; req = vecs[n].req; rel = vecs[n].rel;
      step();
      check_out($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].tmo);
    end

    // hold limit: 16 granted cycles, one idle cycle with timeout, re-grant
    en = 1'b1; req = 8'h80; rel = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      check_out($sformatf("hold%0d", k), 8'h80, 3'd7, 1'b0);
    end
    step();
    check_out("hold_revoke", 8'h00, 3'd0, 1'b1);
    step();
    check_out("hold_regrant", 8'h80, 3'd7, 1'b0);

    // async reset in the middle of a grant of idx 4
    req = 8'h00;
    step();
    check_out("drop7", 8'h00, 3'd0, 1'b0);  // ptr -> 0
    req = 8'h10;
    step();
    check_out("grant4", 8'h10, 3'd4, 1'b0);
    step();
    check_out("grant4_hold", 8'h10, 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h30;
    step();
    check_out("post_rst", 8'h10, 3'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
